fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15, max memory-wait cycles before fault (used only with FETCH_TIMEOUT_EN).
REQ-002 SHALL have a single clock and an asynchronous, active-high reset.
REQ-003 SHALL have ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- pcAddr  in  8  current PC from the address calculation block.
- pcCout  in  1  address-adder carry out.
- memReq  out  1  instruction memory read request.
- memAddr  out  8  read address.
- memRdy  in  1  memory data valid.
- memData  in  16  instruction word.
- zero  in  1  ALU compare result.
- zeroValid  in  1  zero qualifier.
- instr  out  16  registered instruction.
- instrValid  out  1  instruction offered to the datapath.
- instrAck  in  1  datapath accepts instr.
- selAddr  out  2  next-address select: 0 = zero, 1 = PC+1, 2 = PC+label, 3 = addressJ.
- label  out  8  branch offset.
- addressJ  out  8  jump/hold address.
- fault  out  1  sticky error flag.

Function
REQ-004 SHALL implement FSM states BOOT, FETCH, WAIT, ISSUE, RESOLVE, ADVANCE, HALT.
REQ-005 SHALL drive, in every state except BOOT and ADVANCE, selAddr=3 with addressJ=pcAddr, so that the PC holds its value.
REQ-006 SHALL, in BOOT, drive selAddr=0 for one cycle and then go to FETCH.
REQ-007 SHALL, in FETCH, assert memReq with memAddr=pcAddr for exactly one cycle and then go to WAIT.
REQ-008 SHALL, in WAIT, keep memAddr=pcAddr with memReq low; on memRdy, capture memData into instr and go to ISSUE.
REQ-009 SHALL, in ISSUE, hold instrValid high and instr stable until instrAck is sampled high.
REQ-010 SHALL, on acknowledge of an instruction with opcode instr[15:12]:
- OP_BEQ or OP_BNE: go to RESOLVE.
- OP_HALT: go to HALT.
- any other opcode: go to ADVANCE.
REQ-011 SHALL, in RESOLVE, wait for zeroValid; BEQ is taken when zero=1, BNE is taken when zero=0; the taken decision is registered and the FSM then goes to ADVANCE.
REQ-012 SHALL, in ADVANCE, drive for exactly one cycle and then go to FETCH:
- OP_J: selAddr=3, addressJ=instr[7:0].
- taken branch: selAddr=2, label=instr[7:0].
- otherwise: selAddr=1.
REQ-013 SHALL hold label at the registered instr[7:0] in all states.
REQ-014 SHALL, when pcCout=1 in ADVANCE with selAddr 1 or 2, set fault and go to HALT instead of FETCH; PC wrap past 0xFF is an error.
REQ-015 SHALL keep HALT until reset: instrValid=0, memReq=0, PC held.
REQ-016 SHALL ignore memRdy outside WAIT, instrAck outside ISSUE, and zeroValid outside RESOLVE.
REQ-017 SHALL treat memRdy asserted in the same cycle as memReq as not accepted; only WAIT samples memRdy, so minimum fetch latency is 2 cycles.
REQ-018 SHALL make selAddr, addressJ and label combinational from state and registers; all other outputs SHALL be registered.

Reset
REQ-019 SHALL, on rst, immediately force:
- state = BOOT.
- memReq=0, instrValid=0, fault=0.
- instr=16'h0000.
- selAddr=0.
REQ-020 SHALL abort any outstanding fetch when reset is asserted mid-operation; a late memRdy after reset release SHALL be ignored, because the FSM sits in BOOT or FETCH.

Configuration
REQ-021 SHALL, with FETCH_TIMEOUT_EN defined, count WAIT cycles; when the count reaches TIMEOUT_CYCLES without memRdy, it SHALL set fault and go to HALT. The counter SHALL clear on entry to WAIT.
REQ-022 SHALL, without FETCH_TIMEOUT_EN, have no counter, and WAIT SHALL last indefinitely.

Structure
REQ-023 SHALL place opcode constants and the state encoding type in shared package fetch_pkg: OP_J=4'h2, OP_BEQ=4'h4, OP_BNE=4'h5, OP_HALT=4'hF.
REQ-024 SHALL put opcode classification (is_jump, is_branch, is_halt, branch polarity) in one combinational sub-module, instr_class.

Verification
REQ-025 SHALL cover these directed scenarios:
- Reset release, PC=0x00, memRdy 3 cycles after memReq, instr 16'h1234, immediate ack -> instrValid high for 1 cycle, then selAddr=1 for 1 cycle, next memAddr=0x01.
- Fetch 16'h2040 (J) -> ADVANCE drives selAddr=3, addressJ=0x40; next memAddr=0x40.
- Fetch 16'h4005 (BEQ) at PC=0x10, zero=1 with zeroValid after 2 cycles -> selAddr=2, label=0x05; next memAddr=0x15; with zero=0 -> next memAddr=0x11.
- instrAck held low 5 cycles -> instr and instrValid stable, selAddr=3, PC unchanged throughout.
- PC=0xFF, non-branch instr, pcCout=1 -> fault=1, HALT, no further memReq; F000 (HALT) -> no fault, no memReq, PC held.
- FETCH_TIMEOUT_EN defined, memRdy never asserted -> fault=1 after 15 WAIT cycles; reset mid-WAIT -> fault=0, BOOT, selAddr=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch controller.
package fetch_pkg;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned INSTR_W = 16;
    localparam int unsigned OP_W    = 4;

    localparam logic [OP_W-1:0] OP_J    = 4'h2;
    localparam logic [OP_W-1:0] OP_BEQ  = 4'h4;
    localparam logic [OP_W-1:0] OP_BNE  = 4'h5;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_FETCH,
        ST_WAIT,
        ST_ISSUE,
        ST_RESOLVE,
        ST_ADVANCE,
        ST_HALT
    } fetchState_t;

    // Next-address mux select seen by the address calculation block
    typedef enum logic [1:0] {
        SEL_ZERO  = 2'd0,
        SEL_INC   = 2'd1,
        SEL_LABEL = 2'd2,
        SEL_ABS   = 2'd3
    } selAddr_t;

endpackage

// File: rtl/instr_class.sv
// Opcode classification for the fetch controller (pure combinational).
module instr_class
    import fetch_pkg::*;
(
    input  logic [OP_W-1:0] opcode,
    output logic            isJump,
    output logic            isBranch,
    output logic            isHalt,
    output logic            branchOnZero
);

    assign isJump       = (opcode == OP_J);
    assign isBranch     = (opcode == OP_BEQ) || (opcode == OP_BNE);
    assign isHalt       = (opcode == OP_HALT);
    // BEQ takes on zero=1, BNE on zero=0
    assign branchOnZero = (opcode == OP_BEQ);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch / issue / PC-advance controller.
// Define FETCH_TIMEOUT_EN to fault after TIMEOUT_CYCLES memory-wait cycles.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   pcAddr,
    input  logic                pcCout,
    output logic                memReq,
    output logic [ADDR_W-1:0]   memAddr,
    input  logic                memRdy,
    input  logic [INSTR_W-1:0]  memData,
    input  logic                zero,
    input  logic                zeroValid,
    output logic [INSTR_W-1:0]  instr,
    output logic                instrValid,
    input  logic                instrAck,
    output logic [1:0]          selAddr,
    output logic [ADDR_W-1:0]   label,
    output logic [ADDR_W-1:0]   addressJ,
    output logic                fault
);

    fetchState_t       state;
    logic              taken;
    logic              isJump;
    logic              isBranch;
    logic              isHalt;
    logic              branchOnZero;
    selAddr_t          selNext;
    logic [ADDR_W-1:0] addrJNext;
    logic [ADDR_W-1:0] nextPc;
    logic              advOverflow;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] waitCnt;
`endif

    instr_class uClass (
        .opcode       (instr[INSTR_W-1 -: OP_W]),
        .isJump       (isJump),
        .isBranch     (isBranch),
        .isHalt       (isHalt),
        .branchOnZero (branchOnZero)
    );

    // Address select: hold the PC everywhere except BOOT and ADVANCE
    always_comb begin
        selNext   = SEL_ABS;
        addrJNext = pcAddr;
        case (state)
            ST_BOOT:    selNext = SEL_ZERO;
            ST_ADVANCE: begin
                if (isJump) begin
                    selNext   = SEL_ABS;
                    addrJNext = instr[ADDR_W-1:0];
                end else if (taken) begin
                    selNext = SEL_LABEL;
                end else begin
                    selNext = SEL_INC;
                end
            end
            default: ;
        endcase
    end

    assign selAddr  = selNext;
    assign addressJ = addrJNext;
    assign label    = instr[ADDR_W-1:0];

    // The PC the address block will hold after this edge, so the registered
    // memAddr already matches pcAddr during the FETCH cycle
    always_comb begin
        nextPc = addrJNext;
        case (selNext)
            SEL_ZERO:  nextPc = '0;
            SEL_INC:   nextPc = pcAddr + ADDR_W'(1);
            SEL_LABEL: nextPc = pcAddr + label;
            default:   nextPc = addrJNext;
        endcase
    end

    assign advOverflow = pcCout && ((selNext == SEL_INC) || (selNext == SEL_LABEL));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_BOOT;
            memReq     <= 1'b0;
            memAddr    <= '0;
            instr      <= '0;
            instrValid <= 1'b0;
            fault      <= 1'b0;
            taken      <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            waitCnt    <= '0;
`endif
        end else begin
            case (state)
                ST_BOOT: begin
                    memReq  <= 1'b1;
                    memAddr <= nextPc;
                    state   <= ST_FETCH;
                end
                ST_FETCH: begin
                    memReq <= 1'b0;
                    state  <= ST_WAIT;
`ifdef FETCH_TIMEOUT_EN
                    waitCnt <= '0;
`endif
                end
                ST_WAIT: begin
                    if (memRdy) begin
                        instr      <= memData;
                        instrValid <= 1'b1;
                        state      <= ST_ISSUE;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        fault <= 1'b1;
                        state <= ST_HALT;
                    end else begin
                        waitCnt <= waitCnt + CNT_W'(1);
                    end
`endif
                end
                ST_ISSUE: begin
                    if (instrAck) begin
                        instrValid <= 1'b0;
                        taken      <= 1'b0;
                        if (isHalt)
                            state <= ST_HALT;
                        else if (isBranch)
                            state <= ST_RESOLVE;
                        else
                            state <= ST_ADVANCE;
                    end
                end
                ST_RESOLVE: begin
                    if (zeroValid) begin
                        taken <= branchOnZero ? zero : ~zero;
                        state <= ST_ADVANCE;
                    end
                end
                ST_ADVANCE: begin
                    // Carry out of PC+1 / PC+label means the PC wrapped past 0xFF
                    if (advOverflow) begin
                        fault <= 1'b1;
                        state <= ST_HALT;
                    end else begin
                        memReq  <= 1'b1;
                        memAddr <= nextPc;
                        state   <= ST_FETCH;
                    end
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus random instruction stream.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    logic        clk;
    logic        rst;
    logic [7:0]  pcAddr;
    logic        pcCout;
    logic        memReq;
    logic [7:0]  memAddr;
    logic        memRdy;
    logic [15:0] memData;
    logic        zero;
    logic        zeroValid;
    logic [15:0] instr;
    logic        instrValid;
    logic        instrAck;
    logic [1:0]  selAddr;
    logic [7:0]  label;
    logic [7:0]  addressJ;
    logic        fault;

    int nTests;
    int nFail;
    logic [7:0] expPc;
    bit halted;

    fetch_ctrl #(.TIMEOUT_CYCLES(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .pcAddr     (pcAddr),
        .pcCout     (pcCout),
        .memReq     (memReq),
        .memAddr    (memAddr),
        .memRdy     (memRdy),
        .memData    (memData),
        .zero       (zero),
        .zeroValid  (zeroValid),
        .instr      (instr),
        .instrValid (instrValid),
        .instrAck   (instrAck),
        .selAddr    (selAddr),
        .label      (label),
        .addressJ   (addressJ),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Address calculation block environment: PC register and adder carry
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pcAddr <= 8'h5A;
        else
            case (selAddr)
                2'd0:    pcAddr <= 8'h00;
                2'd1:    pcAddr <= pcAddr + 8'd1;
                2'd2:    pcAddr <= pcAddr + label;
                default: pcAddr <= addressJ;
            endcase
    end

    always_comb begin
        pcCout = 1'b0;
        if (selAddr == 2'd1)
            pcCout = (9'(pcAddr) + 9'd1) > 9'd255;
        else if (selAddr == 2'd2)
            pcCout = (9'(pcAddr) + 9'(label)) > 9'd255;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic doReset(input bit lateRdy);
        rst = 1'b1;
        memRdy = 1'b0;
        instrAck = 1'b0;
        zeroValid = 1'b0;
        #1;
        check("rst_memReq", 16'(memReq), 16'd0);
        check("rst_instrValid", 16'(instrValid), 16'd0);
        check("rst_fault", 16'(fault), 16'd0);
        check("rst_instr", instr, 16'h0000);
        check("rst_selAddr", 16'(selAddr), 16'd0);
        tick();
        rst = 1'b0;
        check("boot_selAddr", 16'(selAddr), 16'd0);
        if (lateRdy) begin
            memRdy = 1'b1;
            memData = 16'hBAD0;
        end
        tick();
        memRdy = 1'b0;
        expPc = 8'h00;
    endtask

    // Called at a negedge with the DUT in FETCH; returns at the next FETCH or in HALT
    task automatic runInstr(input logic [15:0] word, input int rdyDly, input int ackDly,
                            input bit zeroVal, input int zvDly, output bit isHalted);
        logic [3:0] op;
        bit tk;
        logic [8:0] sum;
        logic [1:0] expSel;
        op = word[15:12];
        isHalted = 1'b0;
        check("fetch_memReq", 16'(memReq), 16'd1);
        check("fetch_memAddr", 16'(memAddr), 16'(expPc));
        check("fetch_pc", 16'(pcAddr), 16'(expPc));
        memRdy = 1'($urandom_range(0, 1));
        memData = 16'hDEAD;
        tick();
        memRdy = 1'b0;
        for (int i = 1; i < rdyDly; i++) begin
            check("wait_memReq", 16'(memReq), 16'd0);
            check("wait_memAddr", 16'(memAddr), 16'(expPc));
            check("wait_instrValid", 16'(instrValid), 16'd0);
            instrAck = 1'($urandom_range(0, 1));
            zeroValid = 1'($urandom_range(0, 1));
            tick();
        end
        instrAck = 1'b0;
        zeroValid = 1'b0;
        memRdy = 1'b1;
        memData = word;
        tick();
        memRdy = 1'b0;
        memData = 16'($urandom);
        for (int k = 0; k <= ackDly; k++) begin
            check("issue_instrValid", 16'(instrValid), 16'd1);
            check("issue_instr", instr, word);
            check("issue_selAddr", 16'(selAddr), 16'd3);
            check("issue_pc", 16'(pcAddr), 16'(expPc));
            check("issue_memReq", 16'(memReq), 16'd0);
            instrAck = (k == ackDly);
            memRdy = 1'($urandom_range(0, 1));
            tick();
        end
        instrAck = 1'b0;
        memRdy = 1'b0;
        if (op == OP_HALT) begin
            for (int k = 0; k < 5; k++) begin
                check("halt_memReq", 16'(memReq), 16'd0);
                check("halt_instrValid", 16'(instrValid), 16'd0);
                check("halt_fault", 16'(fault), 16'd0);
                check("halt_pc", 16'(pcAddr), 16'(expPc));
                tick();
            end
            isHalted = 1'b1;
            return;
        end
        tk = 1'b0;
        if (op == OP_BEQ || op == OP_BNE) begin
            for (int k = 0; k <= zvDly; k++) begin
                check("resolve_selAddr", 16'(selAddr), 16'd3);
                check("resolve_instrValid", 16'(instrValid), 16'd0);
                zeroValid = (k == zvDly);
                zero = (k == zvDly) ? zeroVal : 1'($urandom_range(0, 1));
                tick();
            end
            zeroValid = 1'b0;
            tk = (op == OP_BEQ) ? zeroVal : !zeroVal;
        end
        if (op == OP_J) begin
            expSel = 2'd3;
            sum = {1'b0, word[7:0]};
            check("adv_addressJ", 16'(addressJ), 16'(word[7:0]));
        end else if (tk) begin
            expSel = 2'd2;
            sum = 9'(expPc) + 9'(word[7:0]);
        end else begin
            expSel = 2'd1;
            sum = 9'(expPc) + 9'd1;
        end
        if (op == OP_J) sum[8] = 1'b0;
        check("adv_selAddr", 16'(selAddr), 16'(expSel));
        check("adv_label", 16'(label), 16'(word[7:0]));
        check("adv_instrValid", 16'(instrValid), 16'd0);
        check("adv_memReq", 16'(memReq), 16'd0);
        tick();
        if (sum[8]) begin
            check("wrap_fault", 16'(fault), 16'd1);
            for (int k = 0; k < 4; k++) begin
                check("wrap_memReq", 16'(memReq), 16'd0);
                check("wrap_pc", 16'(pcAddr), 16'(sum[7:0]));
                tick();
            end
            isHalted = 1'b1;
        end else begin
            check("adv_fault", 16'(fault), 16'd0);
            expPc = sum[7:0];
        end
    endtask

    initial begin
        logic [15:0] w;
        logic [3:0] op;
        rst = 1'b0;
        memRdy = 1'b0;
        memData = 16'h0000;
        zero = 1'b0;
        zeroValid = 1'b0;
        instrAck = 1'b0;
        nTests = 0;
        nFail = 0;
        expPc = 8'h00;
        tick();
        doReset(1'b0);

        runInstr(16'h1234, 3, 0, 1'b0, 0, halted);
        runInstr(16'h2040, 1, 1, 1'b0, 0, halted);
        runInstr(16'h2010, 2, 0, 1'b0, 0, halted);
        runInstr(16'h4005, 1, 0, 1'b1, 2, halted);
        runInstr(16'h2010, 1, 0, 1'b0, 0, halted);
        runInstr(16'h4005, 2, 0, 1'b0, 2, halted);
        runInstr(16'h5003, 1, 0, 1'b0, 1, halted);
        runInstr(16'h5003, 1, 2, 1'b1, 0, halted);
        runInstr(16'h3333, 1, 5, 1'b0, 0, halted);
        runInstr(16'h20FF, 2, 0, 1'b0, 0, halted);
        runInstr(16'h1111, 1, 0, 1'b0, 0, halted);
        check("wrap_halted", 16'(halted), 16'd1);
        doReset(1'b1);
        runInstr(16'h20F0, 1, 0, 1'b0, 0, halted);
        runInstr(16'h4020, 1, 0, 1'b1, 0, halted);
        check("branch_wrap_halted", 16'(halted), 16'd1);
        doReset(1'b0);
        runInstr(16'hF000, 2, 1, 1'b0, 0, halted);
        check("halt_halted", 16'(halted), 16'd1);
        doReset(1'b1);

`ifdef FETCH_TIMEOUT_EN
        check("to_memReq", 16'(memReq), 16'd1);
        tick();
        for (int i = 1; i <= 15; i++) begin
            check("to_wait_fault", 16'(fault), 16'd0);
            check("to_wait_memReq", 16'(memReq), 16'd0);
            tick();
        end
        check("to_fault", 16'(fault), 16'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_halt_memReq", 16'(memReq), 16'd0);
        end
        doReset(1'b1);
        check("to_mid_memReq", 16'(memReq), 16'd1);
        tick();
        for (int i = 0; i < 10; i++) tick();
`else
        check("nto_memReq", 16'(memReq), 16'd1);
        tick();
        for (int i = 0; i < 40; i++) begin
            check("nto_wait_fault", 16'(fault), 16'd0);
            check("nto_wait_memReq", 16'(memReq), 16'd0);
            tick();
        end
`endif
        doReset(1'b1);

        for (int n = 0; n < 40; n++) begin
            op = 4'($urandom_range(0, 14));
            w = {op, 12'($urandom)};
            runInstr(w, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), halted);
            if (halted) doReset(1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
